dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory responder.
package dmem_pkg;

    localparam int DATA_W          = 32;
    localparam int MAX_WAIT_CYCLES = 15;
    localparam int CNT_W           = $clog2(MAX_WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port RAM: synchronous write, registered (read-before-write) output.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed wait-state latency (IDLE/WAIT/ACCESS/DONE).
// Define DMEM_ALIGN_CHECK_EN to reject word-misaligned requests with err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              re,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    op_t               op;
    logic [AW-1:0]     word_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic              accept;
    logic              reject;
    logic              addr_unused;

    // Upper address bits wrap away; byte-lane bits only matter for the alignment check.
    assign addr_unused = ^{addr[31:AW+2], addr[1:0]};

    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        reject = cs && ((we && re) || ((we || re) && (addr[1:0] != 2'b00)));
        accept = cs && (we ^ re) && (addr[1:0] == 2'b00);
`else
        reject = cs && we && re;
        accept = cs && (we ^ re);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            WAIT:    if (cnt <= CNT_W'(1)) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state == ACCESS);
            err   <= (state == IDLE) && reject;
            if (state == IDLE && accept) begin
                cnt <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == DONE && op == OP_READ) begin
                rdata_q <= ram_q;
            end
        end
    end

    // Request latches carry no reset: they are only consumed after an accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            word_q  <= addr[AW+1:2];
            wdata_q <= wdata;
            op      <= we ? OP_WRITE : OP_READ;
        end
    end

    // A reset landing in ACCESS must not let the pending write through.
    assign ram_we = (state == ACCESS) && (op == OP_WRITE) && !rst;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (AW)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .addr (word_q),
        .wdata(wdata_q),
        .rdata(ram_q)
    );

    // The RAM output is live during DONE; afterwards the held copy is shown.
    assign rdata = (state == DONE && op == OP_READ) ? ram_q : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_a = 1'b0, we_a = 1'b0, re_a = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0, rdata_a;
    logic        ready_a, err_a;
    logic        cs_b = 1'b0, we_b = 1'b0, re_b = 1'b0;
    logic [31:0] addr_b = '0, wdata_b = '0, rdata_b;
    logic        ready_b, err_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .cs(cs_a), .we(we_a), .re(re_a),
        .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .cs(cs_b), .we(we_b), .re(re_b),
        .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic c, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            cs_b = c; we_b = w; re_b = r; addr_b = a; wdata_b = d;
        end else begin
            cs_a = c; we_a = w; re_a = r; addr_a = a; wdata_a = d;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction

    // Holds the request until ready, returns edges from accept (1 = sample right after accept edge).
    task automatic do_req(input bit sel, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic ready_after);
        drive(sel, 1'b1, w, r, a, d);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (rdy(sel)) begin
                lat = n;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        ready_after = rdy(sel);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready_a got=%b want=0", ready_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err_a got=%b want=0", err_a); end
        checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL reset_rdata_a got=%h want=0", rdata_a); end
        checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL reset_ready_b got=%b want=0", ready_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int lat;
        logic ra;
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, ra);
        checks++; if (lat !== 4) begin failures++; $display("FAIL wr_latency got=%0d want=4", lat); end
        checks++; if (ra !== 1'b0) begin failures++; $display("FAIL wr_ready_pulse got=%b want=0", ra); end
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, lat, ra);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rd_latency got=%0d want=4", lat); end
        checks++; if (ra !== 1'b0) begin failures++; $display("FAIL rd_ready_pulse got=%b want=0", ra); end
        checks++; if (rdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h want=deadbeef", rdata_a); end
        repeat (3) tick();
        checks++; if (rdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data_hold got=%h want=deadbeef", rdata_a); end
    endtask

    task automatic test_wrap();
        int lat;
        logic ra;
        do_req(0, 1'b1, 1'b0, 32'h1000, 32'h12345678, lat, ra);
        do_req(0, 1'b0, 1'b1, 32'h0, 32'h0, lat, ra);
        checks++; if (lat !== 4) begin failures++; $display("FAIL wrap_latency got=%0d want=4", lat); end
        checks++; if (rdata_a !== 32'h12345678) begin failures++; $display("FAIL wrap_data got=%h want=12345678", rdata_a); end
    endtask

    task automatic test_conflict();
        int lat;
        logic ra;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0);
        tick();
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL conflict_err got=%b want=1", err_a); end
        checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL conflict_ready got=%b want=0", ready_a); end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL conflict_err_pulse got=%b want=0", err_a); end
        lat = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (ready_a) lat++;
        end
        checks++; if (lat !== 0) begin failures++; $display("FAIL conflict_no_ready got=%0d want=0", lat); end
        checks++; if (rdata_a !== 32'h12345678) begin failures++; $display("FAIL conflict_rdata got=%h want=12345678", rdata_a); end
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, lat, ra);
        checks++; if (rdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL conflict_mem got=%h want=deadbeef", rdata_a); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        logic ra;
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h11112222, lat, ra);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'hAAAA5555);
        tick();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL abort_rdata_reset got=%h want=0", rdata_a); end
        rst = 1'b0;
        seen = (ready_a === 1'b1) ? 1 : 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ready_a) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_ready got=%0d want=0", seen); end
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h0, lat, ra);
        checks++; if (rdata_a !== 32'h11112222) begin failures++; $display("FAIL abort_old_data got=%h want=11112222", rdata_a); end
    endtask

    task automatic test_align();
        int lat;
        logic ra;
`ifdef DMEM_ALIGN_CHECK_EN
        int seen;
        drive(0, 1'b1, 1'b0, 1'b1, 32'h22, 32'h0);
        tick();
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL align_err got=%b want=1", err_a); end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ready_a) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL align_no_ready got=%0d want=0", seen); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL align_err_pulse got=%b want=0", err_a); end
`else
        do_req(0, 1'b0, 1'b1, 32'h22, 32'h0, lat, ra);
        checks++; if (lat !== 4) begin failures++; $display("FAIL align_latency got=%0d want=4", lat); end
        checks++; if (rdata_a !== 32'h11112222) begin failures++; $display("FAIL align_data got=%h want=11112222", rdata_a); end
`endif
        do_req(0, 1'b1, 1'b0, 32'h24, 32'h5A5A0F0F, lat, ra);
        do_req(0, 1'b0, 1'b1, 32'h24, 32'h0, lat, ra);
        checks++; if (rdata_a !== 32'h5A5A0F0F) begin failures++; $display("FAIL align_next_word got=%h want=5a5a0f0f", rdata_a); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        logic ra;
        do_req(1, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, lat, ra);
        checks++; if (lat !== 2) begin failures++; $display("FAIL zw_wr_latency got=%0d want=2", lat); end
        do_req(1, 1'b1, 1'b0, 32'h44, 32'h0BADC0DE, lat, ra);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ready_b) begin lat = n; break; end
        end
        checks++; if (lat !== 2) begin failures++; $display("FAIL zw_rd1_latency got=%0d want=2", lat); end
        checks++; if (rdata_b !== 32'hCAFEF00D) begin failures++; $display("FAIL zw_rd1_data got=%h want=cafef00d", rdata_b); end
        drive(1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
        gap = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ready_b) begin gap = n; break; end
        end
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (gap !== 3) begin failures++; $display("FAIL zw_rd2_gap got=%0d want=3", gap); end
        checks++; if (rdata_b !== 32'h0BADC0DE) begin failures++; $display("FAIL zw_rd2_data got=%h want=0badc0de", rdata_b); end
        tick();
        checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL zw_ready_pulse got=%b want=0", ready_b); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_conflict();
        test_reset_abort();
        test_align();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
